// File: rtl/eth_stats_sampler.sv
// Periodic statistics sampler: strobes all collectors on a timer, then drains
// their snapshots one word at a time to a ready/valid stream in round-robin order.

module eth_stats_sampler_lane #(
  parameter int DATA_W = 64
) (
  input  logic              valid,
  input  logic              pending,
  input  logic [DATA_W-1:0] data_in,
  output logic              req,
  output logic [DATA_W-1:0] word
);
  // A collector only competes while its snapshot is still owed this round.
  assign req  = valid & pending;
  assign word = data_in;
endmodule

module eth_stats_sampler #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        time_running,
  input  logic [31:0]                 sample_period,
  output logic                        sample_req,
  input  logic [NUM_PORTS-1:0]        snap_valid,
  input  logic [NUM_PORTS*DATA_W-1:0] snap_data,
  output logic [NUM_PORTS-1:0]        snap_ack,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic [2:0]                  m_port,
  output logic                        m_last,
  output logic [15:0]                 overrun_count,
  output logic                        busy
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_COLLECT, S_OUT} state_t;

  state_t                             state;
  logic [31:0]                        cnt;
  logic [NUM_PORTS-1:0]               pending;
  logic [NUM_PORTS-1:0]               req_m;
  logic [NUM_PORTS-1:0]               gnt_oh;
  logic [NUM_PORTS-1:0][DATA_W-1:0]   words;
  logic [DATA_W-1:0]                  gnt_word;
  logic [2:0]                         last_gnt;
  logic [2:0]                         gnt_idx;
  logic                               gnt_any;
  logic                               expire;
  logic                               in_round;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    eth_stats_sampler_lane #(.DATA_W(DATA_W)) u_lane (
      .valid   (snap_valid[i]),
      .pending (pending[i]),
      .data_in (snap_data[i*DATA_W +: DATA_W]),
      .req     (req_m[i]),
      .word    (words[i])
    );
  end

  // Period expiry; >= rather than == so a shrunken period fires on the next counting cycle.
  assign expire   = (state != S_IDLE) && time_running && (sample_period != 32'd0) &&
                    (cnt >= sample_period - 32'd1);
  assign in_round = (state == S_REQ) || (state == S_COLLECT) || (state == S_OUT);

  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = last_gnt;
    gnt_word = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!gnt_any && req_m[j] && (j == (int'(last_gnt) + k) % NUM_PORTS)) begin
          gnt_any  = 1'b1;
          gnt_idx  = 3'(j);
          gnt_word = words[j];
        end
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int j = 0; j < NUM_PORTS; j++)
      gnt_oh[j] = gnt_any && (gnt_idx == 3'(j));
  end

  // Ack must land in the grant cycle so the collector can drop valid before the next COLLECT.
  assign snap_ack = (state == S_COLLECT) ? gnt_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      pending       <= '0;
      last_gnt      <= 3'(NUM_PORTS - 1);
      overrun_count <= '0;
      sample_req    <= 1'b0;
      m_valid       <= 1'b0;
      m_last        <= 1'b0;
      m_data        <= '0;
      m_port        <= '0;
      busy          <= 1'b0;
    end else begin
      sample_req <= 1'b0;

      if (state == S_IDLE)   cnt <= '0;
      else if (expire)       cnt <= '0;
      else if (time_running) cnt <= cnt + 32'd1;

      if (expire && in_round && (overrun_count != 16'hFFFF))
        overrun_count <= overrun_count + 16'd1;

      case (state)
        S_IDLE: begin
          if (enable && (sample_period != 32'd0)) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (expire) begin
            state      <= S_REQ;
            sample_req <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_REQ: begin
          pending  <= '1;
          last_gnt <= 3'(NUM_PORTS - 1);
          state    <= S_COLLECT;
        end
        S_COLLECT: begin
          if (gnt_any) begin
            pending  <= pending & ~gnt_oh;
            last_gnt <= gnt_idx;
            m_data   <= gnt_word;
            m_port   <= gnt_idx;
            m_last   <= ((pending & ~gnt_oh) == '0);
            m_valid  <= 1'b1;
            state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (pending != '0) begin
              state <= S_COLLECT;
            end else begin
              busy  <= 1'b0;
              state <= enable ? S_WAIT : S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_stats_sampler.sv
// Scoreboard bench for eth_stats_sampler: behavioural collectors respond to sample_req,
// expected words are queued per phase and checked by an independent monitor.

module tb_eth_stats_sampler;
  localparam int NP = 4;
  localparam int DW = 64;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  port;
    logic        last;
  } word_t;

  logic           clk = 1'b0;
  logic           rst, enable, time_running, m_ready;
  logic [31:0]    sample_period;
  logic           sample_req;
  logic [NP-1:0]  snap_valid, snap_ack;
  logic [NP*DW-1:0] snap_data;
  logic           m_valid, m_last, busy;
  logic [DW-1:0]  m_data;
  logic [2:0]     m_port;
  logic [15:0]    overrun_count;

  int    cyc = 0;
  int    n_chk = 0, n_fail = 0, req_cnt = 0;
  word_t exp_q[$];
  logic [31:0] tag = 32'd0;
  int    dly [NP];
  bit    toggle_tr = 1'b0;

  eth_stats_sampler #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .time_running(time_running),
    .sample_period(sample_period), .sample_req(sample_req),
    .snap_valid(snap_valid), .snap_data(snap_data), .snap_ack(snap_ack),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_port(m_port),
    .m_last(m_last), .overrun_count(overrun_count), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  task automatic push_round(input logic [31:0] t, input int p0, input int p1, input int p2, input int p3);
    int    ord [4];
    word_t w;
    ord = '{p0, p1, p2, p3};
    for (int k = 0; k < 4; k++) begin
      w.data = {t, 32'(ord[k])};
      w.port = 3'(ord[k]);
      w.last = (k == 3);
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_req(input int bound, output int c);
    bit found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (sample_req) found = 1'b1;
    end
    if (!found) tmo("wait_sample_req");
    c = cyc;
  endtask

  task automatic drain(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) tmo("drain");
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    req_cnt = 0;
  endtask

  // Reference timer: steady high, or alternating every cycle.
  initial begin : timer
    time_running = 1'b1;
    forever begin
      @(posedge clk);
      #1 time_running = toggle_tr ? ~time_running : 1'b1;
    end
  end

  // Collectors: raise valid dly[i]+1 cycles after the strobe, drop it the cycle after ack.
  initial begin : collector
    logic [NP-1:0] a;
    logic          r, rs;
    int            cd [NP];
    snap_valid = '0;
    snap_data  = '0;
    for (int i = 0; i < NP; i++) cd[i] = -1;
    forever begin
      @(negedge clk);
      a = snap_ack; r = sample_req; rs = rst;
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) begin
        if (rs) begin
          snap_valid[i] = 1'b0;
          cd[i] = -1;
        end else begin
          if (a[i]) snap_valid[i] = 1'b0;
          if (cd[i] > 0) cd[i]--;
          if (r) cd[i] = dly[i];
          if (cd[i] == 0) begin
            snap_valid[i] = 1'b1;
            snap_data[i*DW +: DW] = {tag, 32'(i)};
            cd[i] = -1;
          end
        end
      end
    end
  end

  initial begin : monitor
    word_t e;
    forever begin
      @(negedge clk);
      if (sample_req) req_cnt++;
      if (m_valid) chk("no_ack_in_out", 64'(snap_ack), 64'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got port %0d data 0x%0h, expected none", m_port, m_data);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e.data);
          chk("m_port", 64'(m_port), 64'(e.port));
          chk("m_last", 64'(m_last), 64'(e.last));
        end
      end
    end
  end

  initial begin : stim
    int c_en, c0, c1, c2;
    bit hit;
    rst = 1'b1; enable = 1'b0; m_ready = 1'b1; sample_period = 32'd10;
    dly = '{0, 0, 0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sample_req", 64'(sample_req), 64'd0);
    chk("rst_overrun", 64'(overrun_count), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Period 10, all collectors answer on the first COLLECT cycle, sink always ready.
    tag = 32'hA0A0_0001;
    repeat (3) push_round(tag, 0, 1, 2, 3);
    enable = 1'b1; c_en = cyc;
    wait_req(40, c0);
    chk("first_req_latency", 64'(c0 - c_en), 64'd11);
    wait_req(40, c1);
    chk("req_interval_a1", 64'(c1 - c0), 64'd10);
    wait_req(40, c2);
    chk("req_interval_a2", 64'(c2 - c1), 64'd10);
    @(posedge clk); #1 enable = 1'b0;
    drain(60);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("a_overrun", 64'(overrun_count), 64'd0);
    chk("a_req_count", 64'(req_cnt), 64'd3);
    chk("a_idle_busy", 64'(busy), 64'd0);

    // Collectors ready in order 2,0,3,1: round-robin yields 2,3,0,1.
    do_reset();
    tag = 32'hB0B0_0002;
    dly = '{1, 3, 0, 2};
    push_round(tag, 2, 3, 0, 1);
    enable = 1'b1;
    wait_req(40, c0);
    @(posedge clk); #1 enable = 1'b0;
    drain(60);
    chk("b_overrun", 64'(overrun_count), 64'd0);
    chk("b_req_count", 64'(req_cnt), 64'd1);

    // Period 4 with a stalled sink: word held, overruns accumulate, no extra strobe.
    do_reset();
    tag = 32'hC0C0_0003;
    dly = '{0, 0, 0, 0};
    sample_period = 32'd4;
    m_ready = 1'b0;
    push_round(tag, 0, 1, 2, 3);
    enable = 1'b1;
    wait_req(40, c0);
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      chk("c_hold_valid", 64'(m_valid), 64'd1);
      chk("c_hold_data", m_data, {tag, 32'd0});
    end
    chk("c_overrun_stalled", 64'(overrun_count), 64'd4);
    @(posedge clk); #1 m_ready = 1'b1;
    drain(60);
    chk("c_overrun_final", 64'(overrun_count), 64'd6);
    chk("c_req_count", 64'(req_cnt), 64'd1);

    // Timer running every other cycle, period 8: strobe every 16 cycles.
    do_reset();
    tag = 32'hD0D0_0004;
    sample_period = 32'd8;
    toggle_tr = 1'b1;
    repeat (3) push_round(tag, 0, 1, 2, 3);
    enable = 1'b1;
    wait_req(60, c0);
    wait_req(60, c1);
    chk("req_interval_d1", 64'(c1 - c0), 64'd16);
    wait_req(60, c2);
    chk("req_interval_d2", 64'(c2 - c1), 64'd16);
    @(posedge clk); #1 enable = 1'b0;
    drain(80);
    toggle_tr = 1'b0;
    chk("d_overrun", 64'(overrun_count), 64'd0);
    chk("d_req_count", 64'(req_cnt), 64'd3);

    // Reset while a word is presented and overruns have been counted.
    do_reset();
    tag = 32'hE0E0_0005;
    sample_period = 32'd10;
    m_ready = 1'b0;
    enable = 1'b1;
    wait_req(40, c0);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (overrun_count != 16'd0) hit = 1'b1;
    end
    if (!hit) tmo("e_wait_overrun");
    chk("e_pre_valid", 64'(m_valid), 64'd1);
    chk("e_pre_busy", 64'(busy), 64'd1);
    @(posedge clk); #1 rst = 1'b1; enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("e_rst_valid", 64'(m_valid), 64'd0);
    chk("e_rst_busy", 64'(busy), 64'd0);
    chk("e_rst_overrun", 64'(overrun_count), 64'd0);
    chk("e_rst_last", 64'(m_last), 64'd0);
    chk("e_rst_data", m_data, 64'd0);
    chk("e_rst_ack", 64'(snap_ack), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    req_cnt = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("e_post_req", 64'(req_cnt), 64'd0);

    // Period 0 disables sampling entirely.
    sample_period = 32'd0;
    m_ready = 1'b1;
    enable = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    chk("f_zero_period_req", 64'(req_cnt), 64'd0);
    chk("f_zero_period_busy", 64'(busy), 64'd0);

    // Period 1 with a stalled sink overruns every cycle until saturation.
    m_ready = 1'b0;
    sample_period = 32'd1;
    wait_req(10, c0);
    @(posedge clk); #1 enable = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 70000 && !hit; i++) begin
      @(negedge clk);
      if (overrun_count == 16'hFFFF) hit = 1'b1;
    end
    if (!hit) tmo("f_wait_saturate");
    repeat (4) @(negedge clk);
    chk("f_overrun_sat", 64'(overrun_count), 64'hFFFF);
    chk("f_sat_valid", 64'(m_valid), 64'd1);
    chk("f_sat_req_count", 64'(req_cnt), 64'd1);
    do_reset();
    @(negedge clk);
    chk("f_overrun_cleared", 64'(overrun_count), 64'd0);
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
